// File: rtl/cmp_result_logger.sv
// Logs outcomes of a 4-bit comparator: saturating per-outcome counters plus an
// equal-result streak detector. Define CMP_LOG_ERRCHK_EN to reject non-one-hot samples.
module cmp_result_logger #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned STREAK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic [3:0]       streak_len,
    output logic             streak_hit,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LEN_MAX = 4'd15;
    localparam logic [3:0]       HIT_LEN = 4'(STREAK_N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT
    } state_t;

    state_t state;

    logic onehot_c;
    logic accept_c;
    logic reject_c;

`ifdef CMP_LOG_ERRCHK_EN
    assign onehot_c = ({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) ||
                      ({gt, eq, lt} == 3'b001);
`else
    assign onehot_c = 1'b1;
`endif

    assign accept_c = in_valid && onehot_c;
    assign reject_c = in_valid && !onehot_c;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            gt_cnt     <= '0;
            eq_cnt     <= '0;
            lt_cnt     <= '0;
            total_cnt  <= '0;
            streak_len <= 4'd0;
            streak_hit <= 1'b0;
            err        <= 1'b0;
            state      <= IDLE;
        end else begin
            streak_hit <= 1'b0;
            if (clr) begin
                gt_cnt     <= '0;
                eq_cnt     <= '0;
                lt_cnt     <= '0;
                total_cnt  <= '0;
                streak_len <= 4'd0;
                state      <= IDLE;
            end else if (reject_c) begin
                err        <= 1'b1;
                streak_len <= 4'd0;
                state      <= IDLE;
            end else if (accept_c) begin
                total_cnt <= sat_inc(total_cnt, 1'b1);
                gt_cnt    <= sat_inc(gt_cnt, gt);
                eq_cnt    <= sat_inc(eq_cnt, eq);
                lt_cnt    <= sat_inc(lt_cnt, lt);
                if (!eq) begin
                    streak_len <= 4'd0;
                    state      <= IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            streak_len <= 4'd1;
                            state      <= RUN;
                        end
                        RUN: begin
                            streak_len <= streak_len + 4'd1;
                            if ((streak_len + 4'd1) == HIT_LEN) begin
                                state      <= HIT;
                                streak_hit <= 1'b1;
                            end
                        end
                        // Already announced: keep counting quietly up to the 4-bit limit
                        HIT: begin
                            if (streak_len != LEN_MAX) begin
                                streak_len <= streak_len + 4'd1;
                            end
                        end
                        default: begin
                            streak_len <= 4'd0;
                            state      <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cmp_result_logger.sv
// Self-checking bench for cmp_result_logger: directed scenarios then random traffic,
// all checked against a run-length/counter reference model.
module tb_cmp_result_logger;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STREAK_N = 4;
    localparam int          MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, clr, in_valid, gt, eq, lt;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, total_cnt;
    logic [3:0]       streak_len;
    logic             streak_hit, err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: unbounded run of consecutive accepted eq samples
    int m_gt, m_eq, m_lt, m_tot, m_run;
    bit m_hit, m_err;

    cmp_result_logger #(.CNT_W(CNT_W), .STREAK_N(STREAK_N)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .gt(gt), .eq(eq), .lt(lt),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .total_cnt(total_cnt),
        .streak_len(streak_len), .streak_hit(streak_hit), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    function automatic void model(input bit r, input bit c, input bit v,
                                  input bit g, input bit e, input bit l);
        bit ok;
        m_hit = 1'b0;
        if (r) begin
            m_gt = 0; m_eq = 0; m_lt = 0; m_tot = 0; m_run = 0; m_err = 1'b0;
        end else if (c) begin
            m_gt = 0; m_eq = 0; m_lt = 0; m_tot = 0; m_run = 0;
        end else if (v) begin
            ok = 1'b1;
`ifdef CMP_LOG_ERRCHK_EN
            ok = ((int'(g) + int'(e) + int'(l)) == 1);
`endif
            if (!ok) begin
                m_err = 1'b1;
                m_run = 0;
            end else begin
                m_tot = sat(m_tot + 1);
                if (g) m_gt = sat(m_gt + 1);
                if (e) m_eq = sat(m_eq + 1);
                if (l) m_lt = sat(m_lt + 1);
                if (e) begin
                    m_run = m_run + 1;
                    m_hit = (m_run == int'(STREAK_N));
                end else begin
                    m_run = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gt_cnt"},     32'(gt_cnt),     32'(m_gt));
        chk({tag, ".eq_cnt"},     32'(eq_cnt),     32'(m_eq));
        chk({tag, ".lt_cnt"},     32'(lt_cnt),     32'(m_lt));
        chk({tag, ".total_cnt"},  32'(total_cnt),  32'(m_tot));
        chk({tag, ".streak_len"}, 32'(streak_len), 32'((m_run > 15) ? 15 : m_run));
        chk({tag, ".streak_hit"}, 32'(streak_hit), 32'(m_hit));
        chk({tag, ".err"},        32'(err),        32'(m_err));
    endtask

    // Drive one cycle, let the edge happen, then compare against the model
    task automatic step(input string tag, input bit r, input bit c, input bit v,
                        input bit g, input bit e, input bit l);
        rst = r; clr = c; in_valid = v; gt = g; eq = e; lt = l;
        @(posedge clk);
        #1;
        model(r, c, v, g, e, l);
        check_all(tag);
    endtask

    initial begin
        bit r, c, v, g, e, l;
        int a, b;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; gt = 1'b0; eq = 1'b0; lt = 1'b0;

        // Reset state
        step("rst0", 1, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0);
        chk("rst.total", 32'(total_cnt), 32'd0);

        // gt, eq, lt, eq with one-cycle latency
        step("seq.gt", 0, 0, 1, 1, 0, 0);
        chk("seq.gt_cnt1", 32'(gt_cnt), 32'd1);
        step("seq.eq", 0, 0, 1, 0, 1, 0);
        step("seq.lt", 0, 0, 1, 0, 0, 1);
        step("seq.eq2", 0, 0, 1, 0, 1, 0);
        chk("seq.gt_cnt", 32'(gt_cnt), 32'd1);
        chk("seq.eq_cnt", 32'(eq_cnt), 32'd2);
        chk("seq.lt_cnt", 32'(lt_cnt), 32'd1);
        chk("seq.total",  32'(total_cnt), 32'd4);

        // Streak of four eq with idle gaps, then a fifth
        step("st.clr", 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step("st.idle", 0, 0, 0, 0, 0, 0);
            step("st.eq", 0, 0, 1, 0, 1, 0);
        end
        chk("st.hit4", 32'(streak_hit), 32'd1);
        step("st.after", 0, 0, 0, 0, 0, 0);
        chk("st.hit_drop", 32'(streak_hit), 32'd0);
        step("st.eq5", 0, 0, 1, 0, 1, 0);
        chk("st.len5", 32'(streak_len), 32'd5);
        chk("st.nohit5", 32'(streak_hit), 32'd0);

        // clr beats a valid eq mid-streak
        step("clr.eq", 0, 1, 1, 0, 1, 0);
        chk("clr.eq_cnt", 32'(eq_cnt), 32'd0);
        chk("clr.len", 32'(streak_len), 32'd0);

        // eq, eq, gt, eq -> 1,2,0,1
        step("brk.eq1", 0, 0, 1, 0, 1, 0);
        chk("brk.len1", 32'(streak_len), 32'd1);
        step("brk.eq2", 0, 0, 1, 0, 1, 0);
        chk("brk.len2", 32'(streak_len), 32'd2);
        step("brk.gt", 0, 0, 1, 1, 0, 0);
        chk("brk.len0", 32'(streak_len), 32'd0);
        step("brk.eq3", 0, 0, 1, 0, 1, 0);
        chk("brk.len1b", 32'(streak_len), 32'd1);

        // Saturation with 4-bit counters
        step("sat.clr", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("sat.gt", 0, 0, 1, 1, 0, 0);
        chk("sat.gt_cnt", 32'(gt_cnt), 32'd15);
        chk("sat.total",  32'(total_cnt), 32'd15);

        // Non-one-hot sample {gt,eq,lt}=110
        step("oh.clr", 0, 1, 0, 0, 0, 0);
        step("oh.110", 0, 0, 1, 1, 1, 0);
`ifdef CMP_LOG_ERRCHK_EN
        chk("oh.err", 32'(err), 32'd1);
        chk("oh.gt_cnt", 32'(gt_cnt), 32'd0);
        chk("oh.total", 32'(total_cnt), 32'd0);
`else
        chk("oh.err", 32'(err), 32'd0);
        chk("oh.gt_cnt", 32'(gt_cnt), 32'd1);
        chk("oh.eq_cnt", 32'(eq_cnt), 32'd1);
        chk("oh.total", 32'(total_cnt), 32'd1);
`endif

        // rst mid-streak discards it; samples accepted right after
        step("rm.clr", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("rm.eq", 0, 0, 1, 0, 1, 0);
        step("rm.rst", 1, 0, 1, 0, 1, 0);
        chk("rm.nohit", 32'(streak_hit), 32'd0);
        chk("rm.len", 32'(streak_len), 32'd0);
        step("rm.first", 0, 0, 1, 0, 1, 0);
        chk("rm.first_len", 32'(streak_len), 32'd1);
        chk("rm.first_eq", 32'(eq_cnt), 32'd1);

        // Random traffic from a 4-bit comparator with occasional corrupt flags
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 149) == 0);
            c = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 9) < 7);
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 2) != 0) ? a : int'($urandom_range(0, 15));
            g = (a > b); e = (a == b); l = (a < b);
            if ($urandom_range(0, 9) == 0) {g, e, l} = 3'($urandom);
            step("rnd", r, c, v, g, e, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_result_logger.md
CMP_RESULT_LOGGER -- requirements
Module: cmp_result_logger

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of every outcome counter (range 4..16).
REQ-002 SHALL have parameter STREAK_N, default 4, number of consecutive equal results that declares a streak (range 2..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port clr  input  1  synchronous clear of counters and streak state.
REQ-006 SHALL have port in_valid  input  1  a comparator result is present this cycle.
REQ-007 SHALL have ports gt, eq, lt  input  1 each  the greater, equal and less flags from the upstream 4-bit comparator.
REQ-008 SHALL have ports gt_cnt, eq_cnt, lt_cnt  output  CNT_W each  per-outcome accepted-sample counts.
REQ-009 SHALL have port total_cnt  output  CNT_W  count of all accepted samples.
REQ-010 SHALL have port streak_len  output  4  current run of consecutive equal results.
REQ-011 SHALL have port streak_hit  output  1  one-cycle pulse when a streak reaches STREAK_N.
REQ-012 SHALL have port err  output  1  sticky flag for a non-one-hot flag sample.

Function
REQ-013 SHALL treat a sample as accepted when in_valid=1, clr=0, rst=0 and the sample passes the check in REQ-028 where that check is compiled in.
REQ-014 SHALL register every output, so an accepted sample is reflected on the outputs from the next rising edge (1-cycle latency).
REQ-015 SHALL increment total_cnt and each counter whose flag is set, once per accepted sample.
REQ-016 SHALL saturate every counter at 2^CNT_W-1; further increments hold that value and never wrap.
REQ-017 SHALL leave all state unchanged on cycles with in_valid=0; idle cycles do not break a streak.
REQ-018 SHALL implement the streak FSM with states IDLE, RUN and HIT.
REQ-019 IDLE: an accepted eq=1 sample sets streak_len=1 and moves the FSM to RUN.
REQ-020 RUN: an accepted eq=1 sample increments streak_len; when the new value equals STREAK_N, the FSM moves to HIT and streak_hit=1 for exactly that one cycle.
REQ-021 RUN or HIT: an accepted eq=0 sample sets streak_len=0 and returns the FSM to IDLE.
REQ-022 HIT: further eq=1 samples saturate streak_len at 15, do not re-pulse streak_hit, and keep the FSM in HIT.
REQ-023 SHALL give clr priority over in_valid: the sample in that cycle is discarded, all counters and streak_len go to 0, the FSM goes to IDLE, and streak_hit=0; err is unaffected.
REQ-024 SHALL drive streak_hit=0 on every cycle other than the one named in REQ-020.

Reset
REQ-025 On rst=1 at a rising edge, SHALL set all counters, streak_len, streak_hit and err to 0 and the FSM to IDLE.
REQ-026 SHALL give rst priority over clr and in_valid; asserting rst mid-streak discards the streak, with no streak_hit.
REQ-027 SHALL accept samples from the first edge after rst deasserts.

Configuration
REQ-028 With macro CMP_LOG_ERRCHK_EN defined: a valid sample whose {gt,eq,lt} is not exactly one-hot is rejected (no counter change), sets err=1 (sticky until rst), and returns the streak FSM to IDLE with streak_len=0.
REQ-029 Without CMP_LOG_ERRCHK_EN: every valid sample is accepted, each set flag increments its own counter independently, the streak FSM uses eq alone, and err is tied to 0.

Verification
REQ-030 Reset, then valid samples gt, eq, lt, eq -> gt_cnt=1, eq_cnt=2, lt_cnt=1, total_cnt=4, each count visible one cycle after its sample.
REQ-031 Four consecutive eq samples with idle cycles between them (STREAK_N=4) -> streak_hit pulses once, 1 cycle after the 4th sample; a 5th eq sample gives no pulse and streak_len=5.
REQ-032 Eq, eq, gt, eq -> streak_len sequence 1,2,0,1; no streak_hit.
REQ-033 CNT_W=4: 20 gt samples -> gt_cnt=15 and total_cnt=15, both held there.
REQ-034 clr and in_valid(eq) in the same cycle, mid-streak -> all counters 0, streak_len=0, FSM IDLE; the sample is not counted.
REQ-035 Sample {gt,eq,lt}=110 -> with CMP_LOG_ERRCHK_EN: err=1 and counters unchanged; without it: gt_cnt+1, eq_cnt+1, total_cnt+1, err=0.
